data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//   Off-chip data memory model/controller behind the data cache's memory port.
//   Accepts one 256-bit line read or write per request, responds after a fixed
//   LATENCY with a single-cycle ack. Read data is returned on that ack cycle.
//   Sits directly downstream of dcache_top (mem_enable/mem_write/mem_addr/mem_data).
// PARAMETERS
//   LINE_W   256  line width in bits (data_i/data_o)
//   DEPTH    512  number of lines stored (power of 2)
//   LATENCY  10   cycles from request capture to ack (>=1)
// PORTS
//   clk_i     in   1       clock, rising edge
//   rst_i     in   1       asynchronous reset, active-low
//   enable_i  in   1       request valid; held high by requester until ack_o
//   write_i   in   1       1 = write line, 0 = read line (valid with enable_i)
//   addr_i    in   32      byte address; line index = addr_i[5+:log2(DEPTH)]
//   data_i    in   LINE_W  write data (valid with enable_i & write_i)
//   ack_o     out  1       one-cycle completion pulse
//   data_o    out  LINE_W  read data; valid while ack_o high, held until next read completes
//   busy_o    out  1       high while a request is in progress (WAIT or ACK)
// BEHAVIOUR
//   Reset (rst_i=0, async): state=IDLE, ack_o=0, busy_o=0, data_o=0, counter=0.
//   Storage array is NOT reset; contents survive reset.
//   FSM states: IDLE, WAIT, ACK.
//   - IDLE: at an edge with enable_i=1, latch write_i, line index, and data_i;
//     clear counter; go to WAIT. enable_i=0 -> stay IDLE.
//   - WAIT: counter increments each edge. At the edge where counter==LATENCY-1,
//     go to ACK. On that same edge, a write commits the latched data to the
//     array; a read loads data_o from the array.
//   - ACK: ack_o=1 for exactly this cycle; next edge -> IDLE unconditionally.
//   Timing: request captured at edge E0 -> ack_o high from E0+LATENCY to
//     E0+LATENCY+1. LATENCY=1 gives ack on the cycle right after capture.
//   Inputs are ignored outside IDLE. Changes to addr/data during WAIT have no effect.
//   enable_i still high in the cycle after ack (IDLE) is a new request. The
//     requester drops enable_i when it sees ack_o.
//   Minimum spacing between back-to-back requests is LATENCY+2 cycles.
//   Address wrap: bits above the index field and bits [4:0] are ignored, so an
//     aliasing address hits the same line.
//   Read-after-write to the same line returns the written data (write commits
//     before the later capture).
//   Reset mid-transaction: FSM goes to IDLE, no ack is issued, and a pending
//     write is dropped (the array is unchanged).
//   Counter width is clog2(LATENCY)+1 and it never wraps inside WAIT.
// TESTING
//   1 Reset: rst_i=0 during an active request -> ack_o=0, busy_o=0, data_o=0
//     immediately; no ack after release.
//   2 Write then read: write 256'hA5..A5 @0x0000_0400, then read @0x0000_0400 ->
//     ack exactly 10 cycles after each capture; read data_o=256'hA5..A5.
//   3 Aliasing: write 256'h1 @0x0000_0020, read @0x0000_4020 (DEPTH=512) ->
//     data_o=256'h1. Read @0x0000_0021 -> same line.
//   4 Ignore during busy: change addr_i/data_i/write_i mid-WAIT -> the original
//     request completes unchanged; array is unaffected by the new values.
//   5 Back-to-back: enable_i held high through ack -> second capture one cycle
//     after ack; its ack arrives at E0'+LATENCY.
//   6 LATENCY=1 build: ack_o high on the cycle after capture; busy_o high for
//     exactly 2 cycles.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Line-granular data memory behind the data cache memory port.
// One request at a time: capture in IDLE, wait a fixed latency, then a one-cycle ack.
module data_memory_ctrl #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } state_e;

    state_e            state;
    state_e            next_state;
    logic [CNT_W-1:0]  counter;
    logic              req_write;
    logic [IDX_W-1:0]  req_idx;
    logic [LINE_W-1:0] req_data;
    logic              capture;
    logic              wait_done;

    // Storage is intentionally not reset so contents survive a reset.
    logic [LINE_W-1:0] mem [DEPTH];

    // Offset bits and address bits above the index field alias onto the same line.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

    assign capture   = (state == StIdle) && enable_i;
    assign wait_done = (state == StWait) && (counter == CNT_LAST);

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= StIdle;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; inputs only matter while idle.
    always_comb begin
        next_state = state;
        unique case (state)
            StIdle: if (enable_i) next_state = StWait;
            StWait: if (counter == CNT_LAST) next_state = StAck;
            StAck:  next_state = StIdle;
            default: next_state = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        ack_o  = (state == StAck);
        busy_o = (state != StIdle);
    end

    // Request capture, latency counter and read-data register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            counter   <= '0;
            req_write <= 1'b0;
            req_idx   <= '0;
            req_data  <= '0;
            data_o    <= '0;
        end else begin
            if (capture) begin
                counter   <= '0;
                req_write <= write_i;
                req_idx   <= addr_i[5 +: IDX_W];
                req_data  <= data_i;
            end else if (state == StWait) begin
                // Leaves WAIT at LATENCY-1, so LATENCY fits and it never wraps.
                counter <= counter + CNT_W'(1);
            end
            if (wait_done && !req_write) begin
                data_o <= mem[req_idx];
            end
        end
    end

    // Write commit at the end of WAIT; a reset during WAIT never reaches this edge.
    always_ff @(posedge clk_i) begin
        if (wait_done && req_write) begin
            mem[req_idx] <= req_data;
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: stimulus pushes expected acks, a monitor checks them.
module tb_data_memory_ctrl;

    localparam int unsigned LINE_W  = 256;
    localparam int unsigned DEPTH   = 512;
    localparam int unsigned LATENCY = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable, write;
    logic [31:0]       addr;
    logic [LINE_W-1:0] wdata, rdata;
    logic              ack, busy;

    logic              en1, wr1;
    logic [31:0]       ad1;
    logic [LINE_W-1:0] wd1, rd1;
    logic              ack1, busy1;

    always #5 clk = ~clk;

    data_memory_ctrl #(.LINE_W(LINE_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk_i(clk), .rst_i(rst_n), .enable_i(enable), .write_i(write), .addr_i(addr),
        .data_i(wdata), .ack_o(ack), .data_o(rdata), .busy_o(busy)
    );

    data_memory_ctrl #(.LINE_W(LINE_W), .DEPTH(16), .LATENCY(1)) dut_lat1 (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en1), .write_i(wr1), .addr_i(ad1),
        .data_i(wd1), .ack_o(ack1), .data_o(rd1), .busy_o(busy1)
    );

    typedef struct {
        int          e0;
        int          ack_cyc;
        bit          is_write;
        int          idx;
        logic [255:0] data;
    } exp_t;

    exp_t         sb[$];
    logic [255:0] model [int];
    logic [255:0] last_read = '0;
    int           written[$];
    int           compared = 0;
    int           mismatched = 0;
    int           cyc = 0;
    bit           exp_busy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [255:0] got, logic [255:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic int line_of(logic [31:0] a);
        return int'((a / 32) % DEPTH);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // Random address whose line index is idx: any upper bits, any byte offset.
    function automatic logic [31:0] alias_addr(int idx);
        logic [31:0] r;
        r = $urandom;
        return (r / (32 * DEPTH)) * (32 * DEPTH) + 32'(idx) * 32 + (r % 32);
    endfunction

    // Monitor: every cycle out of reset, compare busy/ack/data against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_busy = (sb.size() > 0) && (cyc >= sb[0].e0);
            check("busy", busy, exp_busy);
            if (ack) begin
                if (sb.size() == 0) begin
                    check("spurious_ack", ack, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_cycle", cyc, e.ack_cyc);
                    if (e.is_write) begin
                        model[e.idx] = e.data;
                    end else begin
                        check("read_data", rdata, e.data);
                        last_read = e.data;
                    end
                end
            end else begin
                check("data_hold", rdata, last_read);
                if (sb.size() > 0 && cyc > sb[0].ack_cyc) begin
                    check("ack_missing", ack, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Call just after a negedge while the DUT will be idle at the next edge.
    task automatic issue(bit w, logic [31:0] a, logic [255:0] d);
        exp_t e;
        enable = 1'b1; write = w; addr = a; wdata = d;
        e.e0       = cyc + 1;
        e.ack_cyc  = cyc + 1 + LATENCY;
        e.is_write = w;
        e.idx      = line_of(a);
        e.data     = w ? d : model[line_of(a)];
        sb.push_back(e);
    endtask

    task automatic wait_ack(bit scramble);
        bit got = 0;
        for (int i = 0; i < int'(LATENCY) + 6; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1;
                break;
            end
            if (scramble) begin
                addr = $urandom; wdata = rand_line(); write = 1'($urandom);
            end
        end
        if (!got) check("ack_timeout", ack, 1);
    endtask

    // One transaction; hold keeps enable high through ack and steps into the idle cycle.
    task automatic txn(bit w, logic [31:0] a, logic [255:0] d, bit scramble, bit hold);
        issue(w, a, d);
        if (w && !written.size()) written.push_back(line_of(a));
        else if (w) begin
            bit seen = 0;
            foreach (written[k]) if (written[k] == line_of(a)) seen = 1;
            if (!seen) written.push_back(line_of(a));
        end
        wait_ack(scramble);
        if (hold) begin
            @(negedge clk);
        end else begin
            enable = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] a5, pat;
        int           ack_at, busy_cnt, start;
        logic [255:0] got1;

        a5 = {32{8'hA5}};
        rst_n = 1'b0; enable = 0; write = 0; addr = 0; wdata = 0;
        en1 = 0; wr1 = 0; ad1 = 0; wd1 = 0;
        repeat (3) @(negedge clk);
        check("reset_ack", ack, 0);
        check("reset_busy", busy, 0);
        check("reset_data", rdata, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Write then read the same line.
        txn(1, 32'h0000_0400, a5, 0, 0);
        @(negedge clk);
        txn(0, 32'h0000_0400, '0, 0, 0);
        @(negedge clk);

        // Aliasing addresses hit the same line.
        txn(1, 32'h0000_0020, 256'h1, 0, 0);
        @(negedge clk);
        txn(0, 32'h0000_4020, '0, 0, 0);
        @(negedge clk);
        txn(0, 32'h0000_0021, '0, 0, 0);
        @(negedge clk);

        // Inputs scrambled during WAIT must not disturb the request.
        txn(1, 32'h0000_0800, rand_line(), 1, 0);
        @(negedge clk);
        txn(0, 32'h0000_0800, '0, 1, 0);
        @(negedge clk);
        txn(0, 32'h0000_0400, '0, 1, 0);
        @(negedge clk);

        // Back-to-back with enable held through ack.
        txn(1, 32'h0000_1000, rand_line(), 0, 1);
        txn(0, 32'h0000_1000, '0, 0, 1);
        txn(0, 32'h0000_0020, '0, 0, 0);
        @(negedge clk);

        // Randomized traffic over a small set of lines with aliased addresses.
        for (int n = 0; n < 40; n++) begin
            int  idx;
            bit  w, hold;
            w    = (written.size() == 0) || ($urandom_range(0, 1) == 1);
            hold = ($urandom_range(0, 3) == 0);
            if (w) idx = ($urandom_range(0, 15) * 33) % DEPTH;
            else   idx = written[$urandom_range(0, written.size() - 1)];
            txn(w, alias_addr(idx), rand_line(), 1'($urandom), hold);
            if (!hold) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        enable = 0;
        repeat (2) @(negedge clk);

        // Reset during a pending write: immediate clear, no ack, write dropped.
        pat = rand_line();
        issue(1, 32'h0000_0400, pat);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_ack", ack, 0);
        check("midreset_busy", busy, 0);
        check("midreset_data", rdata, 0);
        sb.delete();
        last_read = '0;
        enable = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (LATENCY + 4) @(negedge clk);
        txn(0, 32'h0000_0400, '0, 0, 0);
        @(negedge clk);

        // LATENCY=1 instance: ack one cycle after capture, busy for two cycles.
        for (int t = 0; t < 2; t++) begin
            en1 = 1; wr1 = (t == 0); ad1 = 32'h0000_0040; wd1 = (t == 0) ? a5 : '0;
            start = cyc; busy_cnt = 0; ack_at = -1; got1 = '0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (busy1) busy_cnt++;
                if (ack1 && ack_at < 0) begin
                    ack_at = cyc - start;
                    got1   = rd1;
                    en1    = 0;
                end
            end
            check("lat1_ack_cycle", ack_at, 2);
            check("lat1_busy_cycles", busy_cnt, 2);
            if (t == 1) check("lat1_read_data", got1, a5);
        end

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
